// File: rtl/rab_pkg.sv
// rab_pkg: shared entry type and cause bit positions for the RAB miss logger
package rab_pkg;
  localparam int ADDR_W = 32;
  localparam int CAUSE_MISS = 0;
  localparam int CAUSE_MULTI = 1;
  localparam int CAUSE_PROT = 2;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        cause;
    logic              port;
  } miss_entry_t;
endpackage

// File: rtl/rab_sync_fifo.sv
// rab_sync_fifo: DEPTH-entry miss_entry_t FIFO; push when full succeeds only alongside a pop
module rab_sync_fifo
  import rab_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  miss_entry_t            wdata_i,
  output miss_entry_t            rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [$clog2(DEPTH):0] level_next_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  miss_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;
  assign empty_o = level_q == '0;
  assign full_o = level_q == LW'(DEPTH);
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | pop_i);
  assign level_d = level_q + LW'(do_push) - LW'(do_pop);
  assign level_o = level_q;
  assign level_next_o = level_d;
  assign rdata_o = mem[rd_ptr_q];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/rab_miss_logger.sv
// rab_miss_logger: logs rejected RAB transactions into a FIFO with sticky overflow, drop counter and irq
module rab_miss_logger
  import rab_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      int_miss,
  input  logic                      int_multi,
  input  logic                      int_prot,
  input  logic                      port1_drop,
  input  logic                      port2_drop,
  input  logic [ADDR_WIDTH-1:0]     out_addr_reg,
  input  logic                      pop,
  input  logic                      irq_en,
  input  logic                      clr_ovf,
  output logic                      head_valid,
  output logic [ADDR_WIDTH-1:0]     head_addr,
  output logic [2:0]                head_cause,
  output logic                      head_port,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      irq
);
  logic [2:0]                cause_v;
  logic                      evt, full, empty, ovf_evt;
  logic                      overflow_q, overflow_d, irq_q, irq_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [$clog2(DEPTH):0]    level_next;
  logic                      unused_port1;
  miss_entry_t               wr_entry, head;
  assign cause_v[CAUSE_MISS] = int_miss;
  assign cause_v[CAUSE_MULTI] = int_multi;
  assign cause_v[CAUSE_PROT] = int_prot;
  assign evt = |cause_v;
  assign unused_port1 = port1_drop;
  assign wr_entry = '{addr: out_addr_reg, cause: cause_v, port: port2_drop};
  rab_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (s_axi_aclk),
    .rst_n        (s_axi_aresetn),
    .push_i       (evt),
    .pop_i        (pop),
    .wdata_i      (wr_entry),
    .rdata_o      (head),
    .level_o      (level),
    .level_next_o (level_next),
    .full_o       (full),
    .empty_o      (empty)
  );
  assign ovf_evt = evt & full & ~pop;
  assign overflow_d = ovf_evt | (overflow_q & ~clr_ovf);
  // a lost event in the clearing cycle restarts the count at one
  assign drop_cnt_d = ovf_evt ? (clr_ovf ? DROP_CNT_WIDTH'(1) : (&drop_cnt_q ? drop_cnt_q : drop_cnt_q + DROP_CNT_WIDTH'(1)))
                    : clr_ovf ? '0 : drop_cnt_q;
  assign irq_d = irq_en & ((level_next != '0) | overflow_d);
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      irq_q <= irq_d;
    end
  end
  assign head_valid = ~empty;
  assign head_addr = head.addr;
  assign head_cause = head.cause;
  assign head_port = head.port;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_rab_miss_logger.sv
// tb_rab_miss_logger: directed and randomized checks of rab_miss_logger against a queue model
module tb_rab_miss_logger;
  logic        clk = 0;
  logic        rstn = 0;
  logic        i_miss = 0, i_multi = 0, i_prot = 0, p1 = 0, p2 = 0;
  logic [31:0] addr = 0;
  logic        pop = 0, irq_en = 0, clr = 0;
  logic        head_valid, head_port, overflow, irq;
  logic [31:0] head_addr;
  logic [2:0]  head_cause;
  logic [2:0]  level;
  logic [3:0]  drop_cnt;
  int          total = 0, bad = 0;
  logic [35:0] q[$];
  logic        m_ovf = 0, m_irq = 0;
  logic [3:0]  m_drop = 0;

  rab_miss_logger #(.DEPTH(4), .ADDR_WIDTH(32), .DROP_CNT_WIDTH(4)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .int_miss(i_miss), .int_multi(i_multi),
    .int_prot(i_prot), .port1_drop(p1), .port2_drop(p2), .out_addr_reg(addr), .pop(pop),
    .irq_en(irq_en), .clr_ovf(clr), .head_valid(head_valid), .head_addr(head_addr),
    .head_cause(head_cause), .head_port(head_port), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [2:0] c, input logic d1, input logic d2, input logic [31:0] a,
                      input logic pp, input logic cl);
    logic ev, ovf;
    {i_prot, i_multi, i_miss} = c;
    p1 = d1; p2 = d2; addr = a; pop = pp; clr = cl;
    @(posedge clk);
    if (!rstn) begin
      q.delete(); m_ovf = 0; m_drop = 0; m_irq = 0;
    end else begin
      ev = |c;
      ovf = ev && q.size() == 4 && !pp;
      if (pp && q.size() != 0) void'(q.pop_front());
      if (ev && !ovf) q.push_back({a, c, d2});
      if (ovf) m_drop = cl ? 4'd1 : (m_drop == 4'hF ? 4'hF : m_drop + 4'd1);
      else if (cl) m_drop = 0;
      m_ovf = ovf || (m_ovf && !cl);
      m_irq = irq_en && (q.size() != 0 || m_ovf);
    end
    #1;
    {i_prot, i_multi, i_miss} = 0; p1 = 0; p2 = 0; pop = 0; clr = 0;
  endtask

  task automatic idle();
    step(3'b000, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_reset();
    rstn = 0; idle(); idle(); rstn = 1;
    total += 5;
    if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    if (head_valid !== 1'b0) begin bad++; $display("FAIL reset_head_valid got=%b exp=0", head_valid); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    if (drop_cnt !== 4'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_single();
    irq_en = 1;
    step(3'b001, 1, 0, 32'h1000_0040, 0, 0);
    total += 6;
    if (head_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", head_valid); end
    if (head_addr !== 32'h1000_0040) begin bad++; $display("FAIL single_addr got=%h exp=10000040", head_addr); end
    if (head_cause !== 3'b001) begin bad++; $display("FAIL single_cause got=%b exp=001", head_cause); end
    if (head_port !== 1'b0) begin bad++; $display("FAIL single_port got=%b exp=0", head_port); end
    if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    if (irq !== 1'b1) begin bad++; $display("FAIL single_irq got=%b exp=1", irq); end
    step(3'b000, 0, 0, 0, 1, 0);
    total += 2;
    if (level !== 3'd0) begin bad++; $display("FAIL single_drain got=%0d exp=0", level); end
    if (irq !== 1'b0) begin bad++; $display("FAIL single_irq_drop got=%b exp=0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] a_exp;
    for (int i = 0; i < 5; i++) step(3'b001, 1, 0, 32'hA000_0000 + i, 0, 0);
    total += 3;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    if (drop_cnt !== 4'd1) begin bad++; $display("FAIL ovf_drop got=%0d exp=1", drop_cnt); end
    if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
    for (int i = 0; i < 4; i++) begin
      a_exp = 32'hA000_0000 + i;
      total++;
      if (head_addr !== a_exp) begin bad++; $display("FAIL ovf_order%0d got=%h exp=%h", i, head_addr, a_exp); end
      step(3'b000, 0, 0, 0, 1, 0);
    end
    total += 2;
    if (head_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", head_valid); end
    if (irq !== 1'b1) begin bad++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    step(3'b000, 0, 0, 0, 0, 1);
    total += 2;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    if (irq !== 1'b0) begin bad++; $display("FAIL ovf_clr_irq got=%b exp=0", irq); end
  endtask

  task automatic test_full_pop();
    logic [31:0] last;
    for (int i = 0; i < 4; i++) step(3'b010, 0, 1, 32'hB000_0000 + i, 0, 0);
    step(3'b001, 1, 0, 32'hA5A5_0005, 1, 0);
    total += 2;
    if (level !== 3'd4) begin bad++; $display("FAIL fullpop_level got=%0d exp=4", level); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", overflow); end
    last = 0;
    for (int i = 0; i < 4; i++) begin last = head_addr; step(3'b000, 0, 0, 0, 1, 0); end
    total++;
    if (last !== 32'hA5A5_0005) begin bad++; $display("FAIL fullpop_last got=%h exp=a5a50005", last); end
  endtask

  task automatic test_empty_pop();
    step(3'b100, 0, 1, 32'hDEAD_BEE0, 1, 0);
    total += 4;
    if (level !== 3'd1) begin bad++; $display("FAIL emptypop_level got=%0d exp=1", level); end
    if (head_cause !== 3'b100) begin bad++; $display("FAIL emptypop_cause got=%b exp=100", head_cause); end
    if (head_port !== 1'b1) begin bad++; $display("FAIL emptypop_port got=%b exp=1", head_port); end
    if (head_addr !== 32'hDEAD_BEE0) begin bad++; $display("FAIL emptypop_addr got=%h exp=deadbee0", head_addr); end
    step(3'b000, 0, 0, 0, 1, 0);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) step(3'b001, 1, 0, 32'hC000_0000 + i, 0, 0);
    for (int i = 0; i < 19; i++) step(3'b100, 0, 1, 32'hC100_0000 + i, 0, 0);
    total += 2;
    if (drop_cnt !== 4'hF) begin bad++; $display("FAIL sat_drop got=%h exp=f", drop_cnt); end
    if (overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%b exp=1", overflow); end
    step(3'b001, 1, 0, 32'hC200_0000, 0, 1);
    total += 2;
    if (overflow !== 1'b1) begin bad++; $display("FAIL satclr_ovf got=%b exp=1", overflow); end
    if (drop_cnt !== 4'd1) begin bad++; $display("FAIL satclr_drop got=%0d exp=1", drop_cnt); end
    step(3'b000, 0, 0, 0, 0, 1);
    total += 2;
    if (overflow !== 1'b0) begin bad++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
    if (drop_cnt !== 4'd0) begin bad++; $display("FAIL clr_drop got=%0d exp=0", drop_cnt); end
    total++;
    if (head_addr !== 32'hC000_0000) begin bad++; $display("FAIL sat_head got=%h exp=c0000000", head_addr); end
    for (int i = 0; i < 4; i++) step(3'b000, 0, 0, 0, 1, 0);
  endtask

  task automatic test_irq_en();
    irq_en = 0;
    step(3'b001, 1, 0, 32'hD000_0000, 0, 0);
    step(3'b010, 0, 1, 32'hD000_0004, 0, 0);
    total += 2;
    if (irq !== 1'b0) begin bad++; $display("FAIL irqen_off got=%b exp=0", irq); end
    if (level !== 3'd2) begin bad++; $display("FAIL irqen_level got=%0d exp=2", level); end
    irq_en = 1; idle();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irqen_on got=%b exp=1", irq); end
    rstn = 0; step(3'b001, 1, 0, 32'hD000_0008, 0, 0); rstn = 1;
    total += 3;
    if (level !== 3'd0) begin bad++; $display("FAIL midrst_level got=%0d exp=0", level); end
    if (irq !== 1'b0) begin bad++; $display("FAIL midrst_irq got=%b exp=0", irq); end
    if (head_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", head_valid); end
  endtask

  task automatic test_random();
    logic [2:0] c;
    logic       d2;
    for (int n = 0; n < 400; n++) begin
      rstn = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) irq_en = ~irq_en;
      c = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      d2 = 1'($urandom_range(0, 1));
      step(c, (c != 0) && !d2 && ($urandom_range(0, 3) != 0), (c != 0) && d2, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      total += 4;
      if (level !== 3'(q.size())) begin bad++; $display("FAIL rnd_level n=%0d got=%0d exp=%0d", n, level, q.size()); end
      if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, overflow, m_ovf); end
      if (drop_cnt !== m_drop) begin bad++; $display("FAIL rnd_drop n=%0d got=%0d exp=%0d", n, drop_cnt, m_drop); end
      if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
      total++;
      if (head_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, head_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++;
        if ({head_addr, head_cause, head_port} !== q[0]) begin
          bad++; $display("FAIL rnd_head n=%0d got=%h exp=%h", n, {head_addr, head_cause, head_port}, q[0]);
        end
      end
    end
    rstn = 1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pop();
    test_empty_pop();
    test_saturate();
    test_irq_en();
    irq_en = 1;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rab_miss_logger.md
Name: rab_miss_logger

Overview:
- Sits directly downstream of the RAB translation/accept FSM.
- Captures every rejected transaction into a small FIFO that software can read: the faulting address, the cause flags (miss/multi/prot) and the originating port.
- Raises a level interrupt to the host while entries are pending or an overflow has occurred.
- Software pops entries one at a time through the register interface.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- ADDR_WIDTH, 32, width of the logged address
- DROP_CNT_WIDTH, 16, width of the saturating lost-event counter

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  reset; synchronous, active-low
- int_miss  in  1  one-cycle pulse: no TLB hit
- int_multi  in  1  one-cycle pulse: multiple TLB hits
- int_prot  in  1  one-cycle pulse: protection violation
- port1_drop  in  1  drop pulse for port 1; coincident with the int_* pulses
- port2_drop  in  1  drop pulse for port 2
- out_addr_reg  in  ADDR_WIDTH  faulting address; valid in the same cycle as the int_* pulses
- pop  in  1  software read strobe; advances the head
- irq_en  in  1  interrupt enable
- clr_ovf  in  1  clears overflow and drop_cnt
- head_valid  out  1  FIFO not empty
- head_addr  out  ADDR_WIDTH  address of the head entry
- head_cause  out  3  head entry cause flags {prot, multi, miss}
- head_port  out  1  head entry port: 0 = port1, 1 = port2
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky; an event was lost
- drop_cnt  out  DROP_CNT_WIDTH  number of lost events, saturating
- irq  out  1  registered interrupt

Behaviour:
- Reset (s_axi_aresetn == 0 at a clock edge):
  - rd_ptr, wr_ptr, level, overflow, drop_cnt and irq all go to 0.
  - FIFO storage is not cleared.
  - Reset asserted mid-operation discards all pending entries at that edge.
- Event detection:
  - event = int_miss | int_multi | int_prot, sampled each cycle.
  - An entry is {out_addr_reg, {int_prot, int_multi, int_miss}, port2_drop}.
  - port2_drop has priority, though the upstream stage never asserts both drops together.
  - An event with neither drop set is still logged, with port = 0.
- Push: on event, with the FIFO not full, or full with pop in the same cycle.
  - Write at wr_ptr.
  - wr_ptr increments modulo DEPTH.
- Pop: pop while level != 0.
  - rd_ptr increments modulo DEPTH.
  - pop while empty is ignored, with no state change.
- Simultaneous push and pop:
  - Both take effect and level is unchanged.
  - When full, the push succeeds because a slot is freed in the same cycle.
  - When empty, the pop is ignored and the push proceeds, so level becomes 1.
- Overflow: an event while full with no pop.
  - The entry is discarded.
  - overflow is set to 1 at the next edge.
  - drop_cnt increments, saturating at all-ones.
- clr_ovf:
  - Clears overflow and drop_cnt at the next edge.
  - An overflow in the same cycle wins: overflow = 1 and drop_cnt = 1.
- Head outputs:
  - head_valid, head_addr, head_cause and head_port are combinational from storage[rd_ptr] and level.
  - A pushed entry becomes visible 1 cycle after the event edge.
  - head_* fields are don't-care while head_valid = 0.
- irq:
  - Registered: irq <= irq_en & (level_next != 0 | overflow_next).
  - It therefore tracks FIFO state with 1 cycle latency and never glitches.
- Width rules:
  - level spans 0..DEPTH.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- rab_pkg holds:
  - typedef miss_entry_t as a packed struct {addr, cause[2:0], port}
  - constants CAUSE_MISS = 0, CAUSE_MULTI = 1, CAUSE_PROT = 2
- One sub-module, rab_sync_fifo:
  - Generic DEPTH x miss_entry_t storage with pointers, level, full and empty.
  - Push/pop semantics exactly as above.
- Overflow, drop_cnt and irq logic stay in the top module.

Test Plan:
- Reset, then a single int_miss with port1_drop and out_addr_reg = 32'h1000_0040, irq_en = 1:
  - Next cycle: head_valid = 1, head_addr = 32'h1000_0040, head_cause = 3'b001, head_port = 0, level = 1.
  - irq = 1 one cycle after the event edge.
- Four events (DEPTH = 4) with addresses A0..A3, then a fifth event A4 with no pop:
  - overflow = 1, drop_cnt = 1, level = 4.
  - Popping 4 times returns A0..A3 in order, then head_valid = 0.
  - irq stays 1 because overflow is set.
- FIFO full, event A5 coincident with pop:
  - level stays 4, overflow is unchanged, and A5 is the last entry read out.
- FIFO empty, pop with int_prot and port2_drop, addr 32'hDEAD_BEE0:
  - level = 1, head_cause = 3'b100, head_port = 1.
  - pop is ignored.
- Force drop_cnt to saturate: 2^16 + 3 overflow events (reduced DROP_CNT_WIDTH = 4: 19 events):
  - drop_cnt = 4'hF.
  - clr_ovf coincident with a further overflow gives overflow = 1, drop_cnt = 1.
  - clr_ovf alone gives 0, 0.
- irq_en = 0 with 2 pending entries: irq = 0.
  - Raise irq_en: irq = 1 next cycle.
  - Assert reset mid-stream: level = 0, irq = 0, head_valid = 0 after the edge.
